// File: rtl/counter_bcd_range_if.sv
// rtl/counter_bcd_range_if.sv - control/count bundle for the BCD range counter
interface counter_bcd_range_if #(
  parameter int DIGITS = 2
);
  logic                  en;
  logic                  up;
  logic                  ld;
  logic [4*DIGITS-1:0]   d;
  logic [4*DIGITS-1:0]   q;
  logic                  co;
  logic                  ld_err;

  modport master (
    output en, up, ld, d,
    input  q, co, ld_err
  );

  modport slave (
    input  en, up, ld, d,
    output q, co, ld_err
  );
endinterface

// File: rtl/counter_bcd_range.sv
// rtl/counter_bcd_range.sv - multi-digit BCD up/down counter over MINV..MAXV with load and carry
module counter_bcd_range #(
  parameter int DIGITS = 2,
  parameter int MINV   = 0,
  parameter int MAXV   = 59
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  counter_bcd_range_if.slave    bus
);
  localparam int W = 4 * DIGITS;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int r;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      r = r * 10 + int'(b[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic digits_ok(input logic [W-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Only called when Q < MAXV, so the top digit never carries out.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] b);
    logic [W-1:0] r;
    logic c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (b[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = b[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Only called when Q > MINV, so the top digit never borrows out.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] b);
    logic [W-1:0] r;
    logic c;
    r = b;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (b[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = b[4*i +: 4] - 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MINV);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAXV);

  logic [W-1:0] r_q;
  logic         r_ld_err;

  logic         w_at_max;
  logic         w_at_min;
  logic         w_ld_ok;
  logic [W-1:0] w_step;

  assign w_at_max = (r_q == MAX_BCD);
  assign w_at_min = (r_q == MIN_BCD);

  // A load is accepted only if it is well-formed BCD and inside the range.
  assign w_ld_ok  = digits_ok(bus.d) &&
                    (from_bcd(bus.d) >= MINV) && (from_bcd(bus.d) <= MAXV);

  // Next count value when stepping, including wrap at the range ends.
  always_comb begin
    w_step = r_q;
    if (bus.up) begin
      w_step = w_at_max ? MIN_BCD : bcd_inc(r_q);
    end else begin
      w_step = w_at_min ? MAX_BCD : bcd_dec(r_q);
    end
  end

  // Count register and load-reject flag; reset beats load beats count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q      <= MIN_BCD;
      r_ld_err <= 1'b0;
    end else if (bus.ld) begin
      if (w_ld_ok) r_q <= bus.d;
      r_ld_err <= ~w_ld_ok;
    end else begin
      r_ld_err <= 1'b0;
      if (bus.en) r_q <= w_step;
    end
  end

  assign bus.q      = r_q;
  assign bus.ld_err = r_ld_err;
  assign bus.co     = bus.en & (bus.up ? w_at_max : w_at_min);
endmodule

// File: tb/tb_counter_bcd_range.sv
// tb/tb_counter_bcd_range.sv - directed self-checking bench for counter_bcd_range
module tb_counter_bcd_range;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  counter_bcd_range_if #(.DIGITS(2)) a_if ();
  counter_bcd_range_if #(.DIGITS(2)) h_if ();
  counter_bcd_range_if #(.DIGITS(2)) s_if ();
  counter_bcd_range_if #(.DIGITS(2)) m_if ();
  counter_bcd_range_if #(.DIGITS(1)) e_if ();

  counter_bcd_range #(.DIGITS(2), .MINV(0), .MAXV(59)) u_a (.i_clk(clk), .i_rst(rst), .bus(a_if.slave));
  counter_bcd_range #(.DIGITS(2), .MINV(1), .MAXV(12)) u_h (.i_clk(clk), .i_rst(rst), .bus(h_if.slave));
  counter_bcd_range #(.DIGITS(2), .MINV(0), .MAXV(59)) u_s (.i_clk(clk), .i_rst(rst), .bus(s_if.slave));
  counter_bcd_range #(.DIGITS(2), .MINV(0), .MAXV(59)) u_m (.i_clk(clk), .i_rst(rst), .bus(m_if.slave));
  counter_bcd_range #(.DIGITS(1), .MINV(5), .MAXV(5))  u_e (.i_clk(clk), .i_rst(rst), .bus(e_if.slave));

  assign m_if.en = s_if.co;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.en = 1'b1; a_if.up = 1'b1; a_if.ld = 1'b1; a_if.d = 8'h37;
    h_if.en = 1'b0; h_if.up = 1'b1; h_if.ld = 1'b0; h_if.d = 8'h00;
    s_if.en = 1'b0; s_if.up = 1'b1; s_if.ld = 1'b0; s_if.d = 8'h00;
    m_if.up = 1'b1; m_if.ld = 1'b0; m_if.d = 8'h00;
    e_if.en = 1'b0; e_if.up = 1'b1; e_if.ld = 1'b0; e_if.d = 4'h5;
    tick();
    tick();
    n_cmp++; if (a_if.q !== 8'h00) begin n_bad++; $display("FAIL reset_q got %h want 00", a_if.q); end
    n_cmp++; if (a_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL reset_ld_err got %b want 0", a_if.ld_err); end
    n_cmp++; if (a_if.co !== 1'b0) begin n_bad++; $display("FAIL reset_co got %b want 0", a_if.co); end
    n_cmp++; if (h_if.q !== 8'h01) begin n_bad++; $display("FAIL reset_h_q got %h want 01", h_if.q); end
    n_cmp++; if (e_if.q !== 4'h5) begin n_bad++; $display("FAIL reset_e_q got %h want 5", e_if.q); end
    rst = 1'b0;
    a_if.ld = 1'b0; a_if.en = 1'b0;
  endtask

  task automatic test_up_count();
    a_if.ld = 1'b1; a_if.en = 1'b1; a_if.d = 8'h58;
    tick();
    n_cmp++; if (a_if.q !== 8'h58) begin n_bad++; $display("FAIL up_load58 got %h want 58", a_if.q); end
    a_if.ld = 1'b0; a_if.up = 1'b1;
    #1;
    n_cmp++; if (a_if.co !== 1'b0) begin n_bad++; $display("FAIL up_co58 got %b want 0", a_if.co); end
    tick();
    n_cmp++; if (a_if.q !== 8'h59) begin n_bad++; $display("FAIL up_59 got %h want 59", a_if.q); end
    n_cmp++; if (a_if.co !== 1'b1) begin n_bad++; $display("FAIL up_co59 got %b want 1", a_if.co); end
    tick();
    n_cmp++; if (a_if.q !== 8'h00) begin n_bad++; $display("FAIL up_wrap got %h want 00", a_if.q); end
    n_cmp++; if (a_if.co !== 1'b0) begin n_bad++; $display("FAIL up_co00 got %b want 0", a_if.co); end
    a_if.ld = 1'b1; a_if.d = 8'h09;
    tick();
    a_if.ld = 1'b0;
    tick();
    n_cmp++; if (a_if.q !== 8'h10) begin n_bad++; $display("FAIL up_09_10 got %h want 10", a_if.q); end
    a_if.en = 1'b0;
  endtask

  task automatic test_down_count();
    a_if.ld = 1'b1; a_if.d = 8'h00;
    tick();
    a_if.ld = 1'b0; a_if.en = 1'b1; a_if.up = 1'b0;
    #1;
    n_cmp++; if (a_if.co !== 1'b1) begin n_bad++; $display("FAIL dn_co00 got %b want 1", a_if.co); end
    tick();
    n_cmp++; if (a_if.q !== 8'h59) begin n_bad++; $display("FAIL dn_wrap got %h want 59", a_if.q); end
    n_cmp++; if (a_if.co !== 1'b0) begin n_bad++; $display("FAIL dn_co59 got %b want 0", a_if.co); end
    a_if.ld = 1'b1; a_if.d = 8'h10;
    tick();
    a_if.ld = 1'b0;
    tick();
    n_cmp++; if (a_if.q !== 8'h09) begin n_bad++; $display("FAIL dn_10_09 got %h want 09", a_if.q); end
    a_if.en = 1'b0; a_if.up = 1'b1;
  endtask

  task automatic test_load();
    a_if.en = 1'b1; a_if.ld = 1'b1; a_if.d = 8'h37;
    tick();
    n_cmp++; if (a_if.q !== 8'h37) begin n_bad++; $display("FAIL ld_37 got %h want 37", a_if.q); end
    n_cmp++; if (a_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL ld_37_err got %b want 0", a_if.ld_err); end
    a_if.en = 1'b0; a_if.d = 8'h6A;
    tick();
    n_cmp++; if (a_if.q !== 8'h37) begin n_bad++; $display("FAIL ld_6a_q got %h want 37", a_if.q); end
    n_cmp++; if (a_if.ld_err !== 1'b1) begin n_bad++; $display("FAIL ld_6a_err got %b want 1", a_if.ld_err); end
    a_if.ld = 1'b0;
    tick();
    n_cmp++; if (a_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL ld_6a_clr got %b want 0", a_if.ld_err); end
    a_if.ld = 1'b1; a_if.d = 8'h60;
    tick();
    n_cmp++; if (a_if.q !== 8'h37) begin n_bad++; $display("FAIL ld_60_q got %h want 37", a_if.q); end
    n_cmp++; if (a_if.ld_err !== 1'b1) begin n_bad++; $display("FAIL ld_60_err got %b want 1", a_if.ld_err); end
    a_if.ld = 1'b0;
    tick();
    n_cmp++; if (a_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL ld_60_clr got %b want 0", a_if.ld_err); end
    n_cmp++; if (a_if.q !== 8'h37) begin n_bad++; $display("FAIL ld_hold got %h want 37", a_if.q); end
  endtask

  task automatic test_hours();
    h_if.ld = 1'b1; h_if.d = 8'h12;
    tick();
    h_if.ld = 1'b0; h_if.en = 1'b1; h_if.up = 1'b1;
    #1;
    n_cmp++; if (h_if.co !== 1'b1) begin n_bad++; $display("FAIL h_co12 got %b want 1", h_if.co); end
    tick();
    n_cmp++; if (h_if.q !== 8'h01) begin n_bad++; $display("FAIL h_up_wrap got %h want 01", h_if.q); end
    h_if.up = 1'b0;
    #1;
    n_cmp++; if (h_if.co !== 1'b1) begin n_bad++; $display("FAIL h_co01 got %b want 1", h_if.co); end
    tick();
    n_cmp++; if (h_if.q !== 8'h12) begin n_bad++; $display("FAIL h_dn_wrap got %h want 12", h_if.q); end
    tick();
    n_cmp++; if (h_if.q !== 8'h11) begin n_bad++; $display("FAIL h_dn_11 got %h want 11", h_if.q); end
    h_if.en = 1'b0; h_if.ld = 1'b1; h_if.d = 8'h00;
    tick();
    n_cmp++; if (h_if.q !== 8'h11) begin n_bad++; $display("FAIL h_ld00_q got %h want 11", h_if.q); end
    n_cmp++; if (h_if.ld_err !== 1'b1) begin n_bad++; $display("FAIL h_ld00_err got %b want 1", h_if.ld_err); end
    h_if.d = 8'h13;
    tick();
    n_cmp++; if (h_if.ld_err !== 1'b1) begin n_bad++; $display("FAIL h_ld13_err got %b want 1", h_if.ld_err); end
    h_if.d = 8'h01;
    tick();
    n_cmp++; if (h_if.q !== 8'h01) begin n_bad++; $display("FAIL h_ld01 got %h want 01", h_if.q); end
    n_cmp++; if (h_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL h_ld01_err got %b want 0", h_if.ld_err); end
    h_if.ld = 1'b0;
  endtask

  task automatic test_cascade();
    s_if.en = 1'b0; s_if.ld = 1'b1; s_if.d = 8'h59;
    m_if.ld = 1'b1; m_if.d = 8'h59;
    tick();
    s_if.ld = 1'b0; m_if.ld = 1'b0;
    n_cmp++; if ({m_if.q, s_if.q} !== 16'h5959) begin n_bad++; $display("FAIL cas_load got %h want 5959", {m_if.q, s_if.q}); end
    s_if.en = 1'b1; s_if.up = 1'b1; m_if.up = 1'b1;
    #1;
    n_cmp++; if (m_if.co !== 1'b1) begin n_bad++; $display("FAIL cas_min_co got %b want 1", m_if.co); end
    tick();
    n_cmp++; if ({m_if.q, s_if.q} !== 16'h0000) begin n_bad++; $display("FAIL cas_roll got %h want 0000", {m_if.q, s_if.q}); end
    s_if.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({m_if.q, s_if.q, m_if.co, s_if.co} !== 18'h0) begin n_bad++; $display("FAIL cas_hold%0d got %h want 0", i, {m_if.q, s_if.q, m_if.co, s_if.co}); end
    end
  endtask

  task automatic test_equal_range();
    e_if.en = 1'b1; e_if.up = 1'b1;
    #1;
    n_cmp++; if (e_if.co !== 1'b1) begin n_bad++; $display("FAIL eq_co_up got %b want 1", e_if.co); end
    tick();
    e_if.up = 1'b0;
    #1;
    n_cmp++; if (e_if.co !== 1'b1) begin n_bad++; $display("FAIL eq_co_dn got %b want 1", e_if.co); end
    tick();
    n_cmp++; if (e_if.q !== 4'h5) begin n_bad++; $display("FAIL eq_q got %h want 5", e_if.q); end
    e_if.en = 1'b0;
    #1;
    n_cmp++; if (e_if.co !== 1'b0) begin n_bad++; $display("FAIL eq_co_off got %b want 0", e_if.co); end
    e_if.ld = 1'b1; e_if.d = 4'h4;
    tick();
    n_cmp++; if (e_if.ld_err !== 1'b1) begin n_bad++; $display("FAIL eq_ld4_err got %b want 1", e_if.ld_err); end
    e_if.ld = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_if.en = 1'b1; a_if.up = 1'b1; a_if.ld = 1'b1; a_if.d = 8'h6A;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_if.ld = 1'b0; a_if.en = 1'b0;
    n_cmp++; if (a_if.q !== 8'h00) begin n_bad++; $display("FAIL mrst_q got %h want 00", a_if.q); end
    n_cmp++; if (a_if.ld_err !== 1'b0) begin n_bad++; $display("FAIL mrst_err got %b want 0", a_if.ld_err); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_hours();
    test_cascade();
    test_equal_range();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
